// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: load-use stalls, ID redirects,
// instruction-fetch wait and multi-cycle mult/div occupancy of EX.
module hazard_stall_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_RS,
  input  logic [4:0]       ID_RT,
  input  logic             ID_USES_RS,
  input  logic             ID_USES_RT,
  input  logic             ID_MD_START,
  input  logic             EX_MEMREAD,
  input  logic [4:0]       EX_RT,
  input  logic             REDIRECT,
  input  logic             IMEM_READY,
  output logic             PC_WR,
  output logic             IF_ID_WR,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_WR,
  output logic             ID_EX_BUBBLE,
  output logic             EX_MEM_BUBBLE,
  output logic             MD_BUSY,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic {RUN, MD_WAIT} state_t;

  // With MD_LAT==1 the unit finishes in the normal EX slot and never blocks.
  localparam logic       MD_MULTI = (MD_LAT > 1);
  localparam logic [3:0] MD_INIT  = 4'(MD_LAT - 1);

  state_t     state, state_nxt;
  logic [3:0] md_cnt, md_cnt_nxt;
  logic       lu;
  logic       rs_hit, rt_hit;

  // r0 is hardwired, so a load into r0 can never create a real dependency.
  assign rs_hit = ID_USES_RS && (ID_RS == EX_RT);
  assign rt_hit = ID_USES_RT && (ID_RT == EX_RT);
  assign lu     = EX_MEMREAD && (EX_RT != 5'd0) && (rs_hit || rt_hit);

  // NOTE: every output gets a default first so no path can leave one unassigned
  // and infer a latch.
  always_comb begin
    PC_WR         = 1'b0;
    IF_ID_WR      = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_WR      = 1'b0;
    ID_EX_BUBBLE  = 1'b0;
    EX_MEM_BUBBLE = 1'b0;
    MD_BUSY       = 1'b0;
    if (rst_n) begin
      unique case (state)
        RUN: begin
          ID_EX_WR = 1'b1;
          if (lu) begin
            ID_EX_BUBBLE = 1'b1;
          end else if (REDIRECT) begin
            PC_WR       = 1'b1;
            IF_ID_WR    = 1'b1;
            IF_ID_FLUSH = 1'b1;
          end else if (!IMEM_READY) begin
            IF_ID_WR    = 1'b1;
            IF_ID_FLUSH = 1'b1;
          end else begin
            PC_WR    = 1'b1;
            IF_ID_WR = 1'b1;
          end
        end
        MD_WAIT: begin
          EX_MEM_BUBBLE = 1'b1;
          MD_BUSY       = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    unique case (state)
      RUN: begin
        if (ID_MD_START && !lu && MD_MULTI) begin
          state_nxt  = MD_WAIT;
          md_cnt_nxt = MD_INIT;
        end
      end
      MD_WAIT: begin
        // Exit at 1 rather than 0 so the 4-bit counter never underflows.
        md_cnt_nxt = md_cnt - 4'd1;
        if (md_cnt == 4'd1) state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= 4'd0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  // Counts cycles where the PC did not advance; saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      STALL_CNT <= '0;
    end else if (!PC_WR && (STALL_CNT != {CNT_W{1'b1}})) begin
      STALL_CNT <= STALL_CNT + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: one MD_LAT=4/CNT_W=32 instance and one
// MD_LAT=1/CNT_W=3 instance share stimulus; expectations flow through a queue.
module tb_hazard_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, id_md_start, ex_memread, redirect, imem_ready;

  logic        pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_bubble, ex_mem_bubble, md_busy;
  logic [31:0] stall_cnt;
  logic        pc_wr1, if_id_wr1, if_id_flush1, id_ex_wr1, id_ex_bubble1, ex_mem_bubble1, md_busy1;
  logic [2:0]  stall_cnt1;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MD_LAT(4), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .ID_RS(id_rs), .ID_RT(id_rt),
    .ID_USES_RS(id_uses_rs), .ID_USES_RT(id_uses_rt), .ID_MD_START(id_md_start),
    .EX_MEMREAD(ex_memread), .EX_RT(ex_rt), .REDIRECT(redirect), .IMEM_READY(imem_ready),
    .PC_WR(pc_wr), .IF_ID_WR(if_id_wr), .IF_ID_FLUSH(if_id_flush), .ID_EX_WR(id_ex_wr),
    .ID_EX_BUBBLE(id_ex_bubble), .EX_MEM_BUBBLE(ex_mem_bubble), .MD_BUSY(md_busy),
    .STALL_CNT(stall_cnt)
  );

  hazard_stall_ctrl #(.MD_LAT(1), .CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .ID_RS(id_rs), .ID_RT(id_rt),
    .ID_USES_RS(id_uses_rs), .ID_USES_RT(id_uses_rt), .ID_MD_START(id_md_start),
    .EX_MEMREAD(ex_memread), .EX_RT(ex_rt), .REDIRECT(redirect), .IMEM_READY(imem_ready),
    .PC_WR(pc_wr1), .IF_ID_WR(if_id_wr1), .IF_ID_FLUSH(if_id_flush1), .ID_EX_WR(id_ex_wr1),
    .ID_EX_BUBBLE(id_ex_bubble1), .EX_MEM_BUBBLE(ex_mem_bubble1), .MD_BUSY(md_busy1),
    .STALL_CNT(stall_cnt1)
  );

  // Output vector order: {PC_WR, IF_ID_WR, IF_ID_FLUSH, ID_EX_WR, ID_EX_BUBBLE, EX_MEM_BUBBLE, MD_BUSY}
  localparam logic [6:0] O_ZERO  = 7'b000_0000;
  localparam logic [6:0] O_RUN   = 7'b110_1000;
  localparam logic [6:0] O_LU    = 7'b000_1100;
  localparam logic [6:0] O_REDIR = 7'b111_1000;
  localparam logic [6:0] O_IWAIT = 7'b011_1000;
  localparam logic [6:0] O_MDW   = 7'b000_0011;

  typedef struct packed {
    logic [6:0]  o;
    logic [31:0] cnt;
    logic        pc1;
    logic        md1;
    logic [2:0]  cnt1;
  } exp_t;

  exp_t        sb_q[$];
  string       tag_q[$];
  int          total  = 0;
  int          passed = 0;
  logic [31:0] exp_cnt  = '0;
  logic [2:0]  exp_cnt1 = '0;

  task automatic set_in(input logic [4:0] rs, input logic urs, input logic [4:0] rt, input logic urt,
                        input logic mr, input logic [4:0] ert, input logic md,
                        input logic rd, input logic rdy);
    id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
    ex_memread = mr; ex_rt = ert; id_md_start = md; redirect = rd; imem_ready = rdy;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // Called right after a rising edge with inputs already applied; checks at the falling edge.
  task automatic step(input string tag, input logic [6:0] o, input logic pc1);
    exp_t e, got;
    string t;
    if (!rst_n) begin
      exp_cnt  = '0;
      exp_cnt1 = '0;
    end
    e.o = o; e.cnt = exp_cnt; e.pc1 = pc1; e.md1 = 1'b0; e.cnt1 = exp_cnt1;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    got = sb_q.pop_front();
    t   = tag_q.pop_front();
    cmp({t, ".outs"}, 32'({pc_wr, if_id_wr, if_id_flush, id_ex_wr, id_ex_bubble, ex_mem_bubble, md_busy}), 32'(got.o));
    cmp({t, ".stall_cnt"}, stall_cnt, got.cnt);
    cmp({t, ".lat1_pc_wr"}, 32'(pc_wr1), 32'(got.pc1));
    cmp({t, ".lat1_md_busy"}, 32'(md_busy1), 32'(got.md1));
    cmp({t, ".lat1_stall_cnt"}, 32'(stall_cnt1), 32'(got.cnt1));
    if (rst_n) begin
      if (!got.o[6]) exp_cnt = exp_cnt + 32'd1;
      if (!got.pc1 && exp_cnt1 != 3'd7) exp_cnt1 = exp_cnt1 + 3'd1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    step("reset", O_ZERO, 1'b0);
    rst_n = 1'b1;
    step("run", O_RUN, 1'b1);

    // T1: load-use on rs, then on rt
    set_in(5'd5, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    step("lu_rs", O_LU, 1'b0);
    set_in(5'd5, 1'b1, 5'd2, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b1);
    step("lu_rs_after", O_RUN, 1'b1);
    set_in(5'd1, 1'b0, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1);
    step("lu_rt", O_LU, 1'b0);

    // T2: r0 load and unused rs never stall
    set_in(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    step("lu_r0", O_RUN, 1'b1);
    set_in(5'd5, 1'b0, 5'd3, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    step("lu_unused_rs", O_RUN, 1'b1);

    // T3: redirect beats imem wait; load-use beats redirect
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("redir_nordy", O_REDIR, 1'b1);
    set_in(5'd4, 1'b1, 5'd2, 1'b1, 1'b1, 5'd4, 1'b0, 1'b1, 1'b1);
    step("redir_lu", O_LU, 1'b0);
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("imem_wait", O_IWAIT, 1'b0);

    // T4: mult/div occupies EX for MD_LAT-1 cycles; LAT=1 instance keeps running
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    step("md_start", O_RUN, 1'b1);
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("md_wait1", O_MDW, 1'b1);
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    step("md_wait2_ignore", O_IWAIT == O_IWAIT ? O_MDW : O_MDW, 1'b1);
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step("md_wait3_ignore", O_MDW, 1'b0);
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("md_done", O_RUN, 1'b1);

    // mult/div start blocked by load-use must not enter MD_WAIT
    set_in(5'd6, 1'b1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
    step("md_lu", O_LU, 1'b0);
    set_in(5'd6, 1'b1, 5'd2, 1'b1, 1'b0, 5'd6, 1'b0, 1'b0, 1'b1);
    step("md_lu_after", O_RUN, 1'b1);

    // T5: five cycles of fetch wait; the 3-bit counter saturates at 7
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("imem_wait5", O_IWAIT, 1'b0);
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("imem_resume", O_RUN, 1'b1);

    // T6: reset during the second MD_WAIT cycle
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    step("md_start2", O_RUN, 1'b1);
    set_in(5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    step("md2_wait1", O_MDW, 1'b1);
    rst_n = 1'b0;
    step("md2_reset", O_ZERO, 1'b0);
    rst_n = 1'b1;
    step("post_reset_run", O_RUN, 1'b1);
    step("post_reset_run2", O_RUN, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
